// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth signed multiplier: one W+1-bit adder/subtractor stepped W times per operand pair.
// Optional build macro BOOTH_SAT_EN: saturate the W-bit result on overflow instead of wrapping.

module AddSub #(
    parameter int N = 17
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c0,
    output logic [N-1:0] sum,
    output logic         ovf
);
    logic [N-1:0] w_b;

    // c0 both inverts b and supplies the +1, giving a - b when set
    assign w_b = c0 ? ~b : b;
    assign sum = a + w_b + {{(N-1){1'b0}}, c0};
    assign ovf = (a[N-1] == w_b[N-1]) && (sum[N-1] != a[N-1]);
endmodule

module booth_mul_seq #(
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   product,
    output logic [W-1:0]     result,
    output logic             ovf
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [W:0]       r_acc;
    logic [W:0]       r_m;
    logic [W-1:0]     r_q;
    logic             r_q1;
    logic [CW-1:0]    r_count;
    logic             r_busy;
    logic             r_done;
    logic             r_ovf;
    logic [2*W-1:0]   r_product;
    logic [W-1:0]     r_result;

    logic             w_sub;
    logic             w_op;
    logic [W:0]       w_sum;
    logic             w_add_ovf;
    logic             w_unused;
    logic [W:0]       w_acc_sel;
    logic [W:0]       w_acc_sh;
    logic [W-1:0]     w_q_sh;
    logic [2*W-1:0]   w_prod;
    logic             w_ovf;
    logic [W-1:0]     w_res;

    // Booth pair {Q0,q_1}: 10 subtracts M, 01 adds M, 00/11 keep ACC
    assign w_sub = r_q[0] & ~r_q1;
    assign w_op  = r_q[0] ^ r_q1;

    AddSub #(.N(W + 1)) u_addsub (
        .a   (r_acc),
        .b   (r_m),
        .c0  (w_sub),
        .sum (w_sum),
        .ovf (w_add_ovf)
    );

    // The extra guard bit keeps the accumulator in range, so the adder flag never matters
    assign w_unused  = w_add_ovf;

    assign w_acc_sel = w_op ? w_sum : r_acc;
    assign w_acc_sh  = {w_acc_sel[W], w_acc_sel[W:1]};
    assign w_q_sh    = {w_acc_sel[0], r_q[W-1:1]};
    assign w_prod    = {w_acc_sh[W-1:0], w_q_sh};
    assign w_ovf     = ~((&w_prod[2*W-1:W-1]) | ~(|w_prod[2*W-1:W-1]));

`ifdef BOOTH_SAT_EN
    assign w_res = !w_ovf        ? w_prod[W-1:0] :
                   w_prod[2*W-1] ? {1'b1, {(W-1){1'b0}}} :
                                   {1'b0, {(W-1){1'b1}}};
`else
    assign w_res = w_prod[W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_m       <= '0;
            r_q       <= '0;
            r_q1      <= 1'b0;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
            r_product <= '0;
            r_result  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_m     <= {a[W-1], a};
                        r_acc   <= '0;
                        r_q     <= b;
                        r_q1    <= 1'b0;
                        r_count <= CW'(W);
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_acc_sh;
                    r_q     <= w_q_sh;
                    r_q1    <= r_q[0];
                    r_count <= r_count - 1'b1;
                    if (r_count == CW'(1)) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_product <= w_prod;
                        r_result  <= w_res;
                        r_ovf     <= w_ovf;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;
    assign result  = r_result;
    assign ovf     = r_ovf;
endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed-vector bench for booth_mul_seq (W=16); honours BOOTH_SAT_EN for the expected result.

module tb_booth_mul_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic [15:0] result;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    booth_mul_seq #(.W(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .result  (result),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One multiply; optionally pulses start during RUN (cycle 5) and in the DONE cycle
    task automatic run_chk(input string nm, input logic [15:0] ta, input logic [15:0] tbv,
                           input bit inject, input logic [31:0] ep,
                           input logic [15:0] er_sat, input logic [15:0] er_wrap,
                           input logic eo);
        int k;
        int lat;
        int bcyc;
        int ndone;
        logic [15:0] er;
`ifdef BOOTH_SAT_EN
        er = er_sat;
`else
        er = er_wrap;
`endif
        a = ta; b = tbv; start = 1'b1;
        step();
        start = 1'b0;
        k = 1; lat = 0; bcyc = 0; ndone = 0;
        while (ndone == 0 && k <= 60) begin
            if (busy) bcyc++;
            if (done) begin
                ndone = 1;
                lat   = k;
                chk({nm, "_product"}, 64'(product), 64'(ep));
                chk({nm, "_result"},  64'(result),  64'(er));
                chk({nm, "_ovf"},     64'(ovf),     64'(eo));
            end else begin
                if (inject && k == 5) begin
                    start = 1'b1; a = 16'd1; b = 16'd1;
                end else begin
                    start = 1'b0;
                end
                step();
                k++;
            end
        end
        chk({nm, "_done_seen"}, 64'(ndone), 64'd1);
        chk({nm, "_latency"},   64'(lat),   64'd17);
        chk({nm, "_busy_cyc"},  64'(bcyc),  64'd17);
        if (inject) begin
            start = 1'b1; a = 16'd1; b = 16'd1;
        end
        step();
        start = 1'b0;
        chk({nm, "_busy_fall"},   64'(busy),    64'd0);
        chk({nm, "_done_pulse"},  64'(done),    64'd0);
        chk({nm, "_hold_prod"},   64'(product), 64'(ep));
        $display("op %s: a=%0h b=%0h product=%0h result=%0h ovf=%0d lat=%0d",
                 nm, ta, tbv, product, result, ovf, lat);
    endtask

    initial begin
        int ndone;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) step();
        chk("rst_busy",    64'(busy),    64'd0);
        chk("rst_done",    64'(done),    64'd0);
        chk("rst_product", 64'(product), 64'd0);
        chk("rst_result",  64'(result),  64'd0);
        chk("rst_ovf",     64'(ovf),     64'd0);
        rst = 1'b0;
        step();

        run_chk("3x5",     16'd3,      16'd5,      1'b0, 32'd15,        16'd15,     16'd15,     1'b0);
        run_chk("m7x6",    16'hFFF9,   16'd6,      1'b0, 32'hFFFFFFD6,  16'hFFD6,   16'hFFD6,   1'b0);
        run_chk("6xm7",    16'd6,      16'hFFF9,   1'b0, 32'hFFFFFFD6,  16'hFFD6,   16'hFFD6,   1'b0);
        run_chk("minxmin", 16'h8000,   16'h8000,   1'b0, 32'h40000000,  16'h7FFF,   16'h0000,   1'b1);
        run_chk("300xm200",16'd300,    16'hFF38,   1'b0, 32'hFFFF15A0,  16'h8000,   16'h15A0,   1'b1);
        run_chk("maxxmax", 16'h7FFF,   16'h7FFF,   1'b0, 32'h3FFF0001,  16'h7FFF,   16'h0001,   1'b1);
        run_chk("10x10_ign", 16'd10,   16'd10,     1'b1, 32'd100,       16'd100,    16'd100,    1'b0);
        run_chk("after_ign", 16'd7,    16'd8,      1'b0, 32'd56,        16'd56,     16'd56,     1'b0);

        // Abort mid-RUN with start held in the reset cycle
        a = 16'd10; b = 16'd10; start = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        rst = 1'b1; start = 1'b1; a = 16'd1; b = 16'd1;
        step();
        rst = 1'b0; start = 1'b0;
        chk("abort_busy",    64'(busy),    64'd0);
        chk("abort_done",    64'(done),    64'd0);
        chk("abort_product", 64'(product), 64'd0);
        chk("abort_result",  64'(result),  64'd0);
        chk("abort_ovf",     64'(ovf),     64'd0);
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            if (done || busy) ndone++;
            step();
        end
        chk("abort_no_activity", 64'(ndone), 64'd0);
        $display("op abort: product=%0h busy=%0d", product, busy);

        run_chk("m1xm1", 16'hFFFF, 16'hFFFF, 1'b0, 32'd1, 16'd1, 16'd1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
